cpu6_memarb: RTL and testbench
==============================

Name: cpu6_memarb

Overview:
Arbiter and sequencer for the single synchronous-RAM data port of the cpu6 SoC. It shares the port between two requesters: the core load/store path (requester 0) and a DMA/debug master (requester 1). One access is granted at a time, with fixed two-cycle timing (issue, then response). Priority is round-robin or core-priority, and a starvation counter guarantees the DMA requester makes progress.

Parameters:
XLEN, 32, address/data width (matches CPU6_XLEN)
CORE_PRIO, 1, 1 = core wins every tie; 0 = round-robin between requesters
MAX_WAIT, 8, number of lost arbitrations after which a waiting DMA request is forced to win (range 1..255)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
core_req  input  1  core access request; held until core_ack
core_we  input  1  1 = write, 0 = read; stable while core_req
core_addr  input  XLEN  byte address; stable while core_req
core_wdata  input  XLEN  write data; stable while core_req
core_ack  output  1  one-cycle completion pulse
core_rdata  output  XLEN  read data, valid only when core_ack=1, else 0
dma_req  input  1  DMA request; same rules as core_req
dma_we  input  1  DMA write enable
dma_addr  input  XLEN  DMA address
dma_wdata  input  XLEN  DMA write data
dma_ack  output  1  one-cycle completion pulse
dma_rdata  output  XLEN  read data, valid only when dma_ack=1, else 0
mem_en  output  1  RAM access strobe
mem_we  output  1  RAM write enable, qualified by mem_en
mem_addr  output  XLEN  RAM address
mem_wdata  output  XLEN  RAM write data
mem_rdata  input  XLEN  RAM read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Reset and clocking:
  - One clock domain. Reset is synchronous and active-high.
  - Reset sets: state=IDLE, grant=none, last_grant=DMA (so the core wins the first round-robin tie), wait_cnt=0.
  - Reset drives all outputs 0: acks, rdata, mem_en, mem_we, mem_addr, mem_wdata.
- States: IDLE, RESP.
- IDLE:
  - Arbitration is combinational from the current request inputs.
  - If any req is high, the winner's we/addr/wdata drive mem_* in the same cycle and mem_en=1.
  - On the next edge: state becomes RESP, grant is registered, and last_grant is updated.
  - If no req is high: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- RESP:
  - mem_en=0.
  - The granted requester's ack=1. For a read, its rdata=mem_rdata.
  - For a write, ack=1 and rdata=0.
  - Next edge: state returns to IDLE.
  - Throughput is one access per 2 cycles. The requester drops or renews req in the cycle after its ack.
- Winner selection, in priority order:
  1. dma_req and wait_cnt==MAX_WAIT: DMA wins.
  2. Only one req high: that requester wins.
  3. Both high, CORE_PRIO=1: core wins.
  4. Both high, CORE_PRIO=0: the requester not equal to last_grant wins.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, on each IDLE cycle where dma_req=1 and the core wins.
  - Clears when DMA is granted.
  - Holds otherwise.
- Ack behaviour:
  - An ack never asserts in IDLE.
  - At most one ack is high per cycle. core_ack and dma_ack are never high together.
- Request dropped between issue and RESP: protocol violation. The ack is still generated and the RAM access has already occurred. There is no assertion logic in RTL.
- Reset asserted in RESP: the ack is suppressed in that cycle and the next state is IDLE. A write issued in the prior IDLE cycle has already reached the RAM.
- Address and width: pass-through, with no alignment checks. Byte-lane handling belongs to the requester.

Test Plan:
- Reset then single core read: reset=1 for 2 cycles; then core_req=1, we=0, addr=0x100, RAM[0x100]=0xDEADBEEF. Required: mem_en=1 with addr=0x100 in cycle 0; core_ack=1 and core_rdata=0xDEADBEEF in cycle 1; dma_ack=0 throughout.
- DMA write then read-back: dma write addr=0x40, wdata=0x12345678, then dma read addr=0x40. Required: mem_we=1 in write issue cycle; dma_ack pulses at cycles 1 and 3; second dma_rdata=0x12345678.
- Simultaneous requests, CORE_PRIO=0: both req held continuously. Required: grants alternate core, dma, core, dma with acks at cycles 1, 3, 5, 7 (core first after reset).
- Starvation, CORE_PRIO=1, MAX_WAIT=3: core_req and dma_req held high. Required: three core grants, then a DMA grant on the 4th issue; wait_cnt returns to 0; pattern repeats.
- Reset mid-operation: core read issued, reset=1 in the RESP cycle. Required: core_ack=0 that cycle; next cycle state IDLE and all outputs 0.
- Idle and ack exclusivity: no reqs for 10 cycles, then 200 random cycles with both masters. Required: mem_en=0 while idle; core_ack&dma_ack never 1; every ack exactly 1 cycle after its mem_en issue.

Source files
------------

// File: rtl/cpu6_memarb.sv
`default_nettype none
// ============================================================================
//  Module   : cpu6_memarb
//  Purpose  : Two-requester arbiter/sequencer for the cpu6 synchronous-RAM
//             data port. Requester 0 is the core load/store path and
//             requester 1 is the DMA/debug master. Each access takes two
//             cycles (issue, then response). Ties are resolved by fixed core
//             priority or by round-robin. A wait counter forces a starved DMA
//             request to win.
//  Revision : 1.0  initial release
// ============================================================================
module cpu6_memarb #(
   parameter int XLEN      = 32,
   parameter int CORE_PRIO = 1,
   parameter int MAX_WAIT  = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            core_req,
   input  logic            core_we,
   input  logic [XLEN-1:0] core_addr,
   input  logic [XLEN-1:0] core_wdata,
   output logic            core_ack,
   output logic [XLEN-1:0] core_rdata,
   input  logic            dma_req,
   input  logic            dma_we,
   input  logic [XLEN-1:0] dma_addr,
   input  logic [XLEN-1:0] dma_wdata,
   output logic            dma_ack,
   output logic [XLEN-1:0] dma_rdata,
   output logic            mem_en,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RESP = 1'b1;

   localparam logic [7:0] c_MAX_WAIT = 8'(MAX_WAIT);

   logic [0:0] r_state;
   logic       r_gnt_dma;    // 1 = the access in flight belongs to DMA
   logic       r_gnt_we;     // the access in flight is a write
   logic       r_last_dma;   // last grant went to DMA (round-robin memory)
   logic [7:0] r_wait_cnt;   // arbitrations DMA lost while requesting

   logic w_any_req;
   logic w_dma_win;
   logic w_win_we;
   logic w_issue;
   logic w_resp;

   // Winner selection: starvation override first, then sole requester,
   // then the tie-break policy.
   always_comb begin
      w_any_req = core_req | dma_req;
      w_dma_win = 1'b0;
      if (dma_req) begin
         if (r_wait_cnt == c_MAX_WAIT) begin
            w_dma_win = 1'b1;
         end else if (!core_req) begin
            w_dma_win = 1'b1;
         end else if (CORE_PRIO == 0) begin
            w_dma_win = ~r_last_dma;
         end
      end
      w_win_we = w_dma_win ? dma_we : core_we;
      // Outputs are forced quiet while reset is held, even mid-access.
      w_issue  = (r_state == S_IDLE) && w_any_req && !reset;
      w_resp   = (r_state == S_RESP) && !reset;
   end

   // RAM port drive: the winner's command is presented in the issue cycle.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (w_issue) begin
         mem_en    = 1'b1;
         mem_we    = w_win_we;
         mem_addr  = w_dma_win ? dma_addr  : core_addr;
         mem_wdata = w_dma_win ? dma_wdata : core_wdata;
      end
   end

   // Response: one-cycle ack to the granted requester, read data only on reads.
   always_comb begin
      core_ack   = w_resp & ~r_gnt_dma;
      dma_ack    = w_resp &  r_gnt_dma;
      core_rdata = (core_ack && !r_gnt_we) ? mem_rdata : '0;
      dma_rdata  = (dma_ack  && !r_gnt_we) ? mem_rdata : '0;
   end

   // Sequencer state, grant record and DMA starvation counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_gnt_dma  <= 1'b0;
         r_gnt_we   <= 1'b0;
         r_last_dma <= 1'b1;
         r_wait_cnt <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_state    <= S_RESP;
                  r_gnt_dma  <= w_dma_win;
                  r_gnt_we   <= w_win_we;
                  r_last_dma <= w_dma_win;
                  if (w_dma_win) begin
                     r_wait_cnt <= 8'd0;
                  end else if (dma_req && (r_wait_cnt < c_MAX_WAIT)) begin
                     r_wait_cnt <= r_wait_cnt + 8'd1;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cpu6_memarb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu6_memarb
//  Purpose  : Self-checking bench for cpu6_memarb. Instance 0 runs
//             round-robin (MAX_WAIT=8), instance 1 runs core priority with
//             MAX_WAIT=3. A word-addressed synchronous RAM sits behind each.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu6_memarb;

   logic        clk = 1'b0;
   logic        reset      [2];
   logic        core_req   [2];
   logic        core_we    [2];
   logic [31:0] core_addr  [2];
   logic [31:0] core_wdata [2];
   logic        core_ack   [2];
   logic [31:0] core_rdata [2];
   logic        dma_req    [2];
   logic        dma_we     [2];
   logic [31:0] dma_addr   [2];
   logic [31:0] dma_wdata  [2];
   logic        dma_ack    [2];
   logic [31:0] dma_rdata  [2];
   logic        mem_en     [2];
   logic        mem_we     [2];
   logic [31:0] mem_addr   [2];
   logic [31:0] mem_wdata  [2];
   logic [31:0] mem_rdata  [2];

   logic [31:0] ram [2][256];

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state (transaction level)
   logic [31:0] m_mem      [2][256];
   int          m_wait     [2];
   bit          m_last_dma [2];

   always #5 clk = ~clk;

   for (genvar k = 0; k < 2; k++) begin : g_dut
      cpu6_memarb #(
         .XLEN      (32),
         .CORE_PRIO ((k == 0) ? 0 : 1),
         .MAX_WAIT  ((k == 0) ? 8 : 3)
      ) u_dut (
         .clk        (clk),
         .reset      (reset[k]),
         .core_req   (core_req[k]),
         .core_we    (core_we[k]),
         .core_addr  (core_addr[k]),
         .core_wdata (core_wdata[k]),
         .core_ack   (core_ack[k]),
         .core_rdata (core_rdata[k]),
         .dma_req    (dma_req[k]),
         .dma_we     (dma_we[k]),
         .dma_addr   (dma_addr[k]),
         .dma_wdata  (dma_wdata[k]),
         .dma_ack    (dma_ack[k]),
         .dma_rdata  (dma_rdata[k]),
         .mem_en     (mem_en[k]),
         .mem_we     (mem_we[k]),
         .mem_addr   (mem_addr[k]),
         .mem_wdata  (mem_wdata[k]),
         .mem_rdata  (mem_rdata[k])
      );
   end

   // Synchronous RAM behind each arbiter; reset loads a known image.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (reset[k]) begin
            for (int i = 0; i < 256; i++) ram[k][i] <= '0;
            ram[k][64] <= 32'hDEADBEEF;
         end else if (mem_en[k]) begin
            if (mem_we[k]) ram[k][mem_addr[k][9:2]] <= mem_wdata[k];
            else           mem_rdata[k] <= ram[k][mem_addr[k][9:2]];
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs(int k);
      core_req[k] = 0; core_we[k] = 0; core_addr[k] = '0; core_wdata[k] = '0;
      dma_req[k]  = 0; dma_we[k]  = 0; dma_addr[k]  = '0; dma_wdata[k]  = '0;
   endtask

   task automatic model_reset(int k);
      for (int i = 0; i < 256; i++) m_mem[k][i] = '0;
      m_mem[k][64]  = 32'hDEADBEEF;
      m_wait[k]     = 0;
      m_last_dma[k] = 1'b1;
   endtask

   task automatic do_reset(int k);
      clear_inputs(k);
      reset[k] = 1'b1;
      step();
      step();
      reset[k] = 1'b0;
      model_reset(k);
   endtask

   // Arbitration rules at transaction level; returns 1 if DMA wins.
   function automatic bit model_pick(int k, bit c, bit d);
      int  max_w = (k == 0) ? 8 : 3;
      bit  cprio = (k != 0);
      bit  dwin;
      if (!d)                    dwin = 1'b0;
      else if (m_wait[k] == max_w) dwin = 1'b1;
      else if (!c)               dwin = 1'b1;
      else if (cprio)            dwin = 1'b0;
      else                       dwin = !m_last_dma[k];
      if (dwin) m_wait[k] = 0;
      else if (d && m_wait[k] < max_w) m_wait[k] = m_wait[k] + 1;
      m_last_dma[k] = dwin;
      return dwin;
   endfunction

   task automatic test_reset(int k);
      clear_inputs(k);
      reset[k] = 1'b1;
      core_req[k] = 1; core_addr[k] = 32'h100;
      dma_req[k]  = 1; dma_addr[k]  = 32'h40;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_tests++;
         if (mem_en[k] !== 1'b0 || mem_addr[k] !== 32'h0 || mem_we[k] !== 1'b0 || mem_wdata[k] !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mem[%0d]: got en=%b we=%b addr=%h wdata=%h, required all 0", k, mem_en[k], mem_we[k], mem_addr[k], mem_wdata[k]);
         end
         n_tests++;
         if (core_ack[k] !== 1'b0 || dma_ack[k] !== 1'b0 || core_rdata[k] !== 32'h0 || dma_rdata[k] !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_ack[%0d]: got cack=%b dack=%b crd=%h drd=%h, required all 0", k, core_ack[k], dma_ack[k], core_rdata[k], dma_rdata[k]);
         end
         step();
      end
      reset[k] = 1'b0;
      clear_inputs(k);
      model_reset(k);
   endtask

   task automatic test_core_read(int k);
      do_reset(k);
      core_req[k] = 1; core_we[k] = 0; core_addr[k] = 32'h100;
      @(negedge clk);
      n_tests++;
      if (mem_en[k] !== 1'b1 || mem_addr[k] !== 32'h100 || mem_we[k] !== 1'b0 || dma_ack[k] !== 1'b0 || core_ack[k] !== 1'b0) begin
         n_fail++;
         $display("FAIL core_rd_issue: got en=%b we=%b addr=%h cack=%b dack=%b, required en=1 we=0 addr=100 acks 0", mem_en[k], mem_we[k], mem_addr[k], core_ack[k], dma_ack[k]);
      end
      step();
      @(negedge clk);
      n_tests++;
      if (core_ack[k] !== 1'b1 || core_rdata[k] !== 32'hDEADBEEF || dma_ack[k] !== 1'b0 || mem_en[k] !== 1'b0) begin
         n_fail++;
         $display("FAIL core_rd_resp: got cack=%b rdata=%h dack=%b en=%b, required cack=1 rdata=deadbeef dack=0 en=0", core_ack[k], core_rdata[k], dma_ack[k], mem_en[k]);
      end
      step();
      core_req[k] = 0;
      @(negedge clk);
      n_tests++;
      if (core_ack[k] !== 1'b0 || core_rdata[k] !== 32'h0 || mem_en[k] !== 1'b0) begin
         n_fail++;
         $display("FAIL core_rd_after: got cack=%b rdata=%h en=%b, required 0", core_ack[k], core_rdata[k], mem_en[k]);
      end
      step();
   endtask

   task automatic test_dma_wr_rd(int k);
      do_reset(k);
      dma_req[k] = 1; dma_we[k] = 1; dma_addr[k] = 32'h40; dma_wdata[k] = 32'h12345678;
      @(negedge clk);
      n_tests++;
      if (mem_en[k] !== 1'b1 || mem_we[k] !== 1'b1 || mem_addr[k] !== 32'h40 || mem_wdata[k] !== 32'h12345678 || dma_ack[k] !== 1'b0) begin
         n_fail++;
         $display("FAIL dma_wr_issue: got en=%b we=%b addr=%h wdata=%h dack=%b, required 1 1 40 12345678 0", mem_en[k], mem_we[k], mem_addr[k], mem_wdata[k], dma_ack[k]);
      end
      step();
      @(negedge clk);
      n_tests++;
      if (dma_ack[k] !== 1'b1 || dma_rdata[k] !== 32'h0 || core_ack[k] !== 1'b0) begin
         n_fail++;
         $display("FAIL dma_wr_resp: got dack=%b rdata=%h cack=%b, required dack=1 rdata=0 cack=0", dma_ack[k], dma_rdata[k], core_ack[k]);
      end
      step();
      dma_we[k] = 0; dma_wdata[k] = 32'hFFFF0000;
      @(negedge clk);
      n_tests++;
      if (mem_en[k] !== 1'b1 || mem_we[k] !== 1'b0 || mem_addr[k] !== 32'h40 || dma_ack[k] !== 1'b0) begin
         n_fail++;
         $display("FAIL dma_rd_issue: got en=%b we=%b addr=%h dack=%b, required 1 0 40 0", mem_en[k], mem_we[k], mem_addr[k], dma_ack[k]);
      end
      step();
      @(negedge clk);
      n_tests++;
      if (dma_ack[k] !== 1'b1 || dma_rdata[k] !== 32'h12345678) begin
         n_fail++;
         $display("FAIL dma_rd_resp: got dack=%b rdata=%h, required dack=1 rdata=12345678", dma_ack[k], dma_rdata[k]);
      end
      step();
      clear_inputs(k);
   endtask

   // Both requesters held; expected grant order given as a repeating pattern.
   task automatic test_contention(int k, int period, string name);
      do_reset(k);
      core_req[k] = 1; core_addr[k] = 32'h100;
      dma_req[k]  = 1; dma_addr[k]  = 32'h104;
      for (int c = 0; c < 16; c++) begin
         int  g    = c / 2;
         bit  xdma = (period == 2) ? (g % 2 == 1) : (g % period == period - 1);
         @(negedge clk);
         n_tests++;
         if (c % 2 == 0) begin
            if (mem_en[k] !== 1'b1 || mem_addr[k] !== (xdma ? 32'h104 : 32'h100) || core_ack[k] !== 1'b0 || dma_ack[k] !== 1'b0) begin
               n_fail++;
               $display("FAIL %s_issue g%0d: got en=%b addr=%h cack=%b dack=%b, required en=1 addr=%h acks 0", name, g, mem_en[k], mem_addr[k], core_ack[k], dma_ack[k], xdma ? 32'h104 : 32'h100);
            end
         end else begin
            if (core_ack[k] !== !xdma || dma_ack[k] !== xdma || mem_en[k] !== 1'b0 || core_rdata[k] !== (xdma ? 32'h0 : 32'hDEADBEEF)) begin
               n_fail++;
               $display("FAIL %s_ack g%0d: got cack=%b dack=%b en=%b crd=%h, required cack=%b dack=%b en=0", name, g, core_ack[k], dma_ack[k], mem_en[k], core_rdata[k], !xdma, xdma);
            end
         end
         step();
      end
      clear_inputs(k);
   endtask

   task automatic test_reset_mid(int k);
      do_reset(k);
      core_req[k] = 1; core_we[k] = 0; core_addr[k] = 32'h100;
      @(negedge clk);
      n_tests++;
      if (mem_en[k] !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_issue: got en=%b, required 1", mem_en[k]);
      end
      step();
      reset[k] = 1'b1;
      @(negedge clk);
      n_tests++;
      if (core_ack[k] !== 1'b0 || core_rdata[k] !== 32'h0 || dma_ack[k] !== 1'b0 || mem_en[k] !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_resp: got cack=%b crd=%h dack=%b en=%b, required all 0", core_ack[k], core_rdata[k], dma_ack[k], mem_en[k]);
      end
      step();
      reset[k] = 1'b0;
      model_reset(k);
      core_req[k] = 0;
      @(negedge clk);
      n_tests++;
      if (core_ack[k] !== 1'b0 || dma_ack[k] !== 1'b0 || mem_en[k] !== 1'b0 || mem_we[k] !== 1'b0 || mem_addr[k] !== 32'h0 || mem_wdata[k] !== 32'h0 || core_rdata[k] !== 32'h0) begin
         n_fail++;
         $display("FAIL rstmid_after: got cack=%b dack=%b en=%b we=%b addr=%h, required all 0", core_ack[k], dma_ack[k], mem_en[k], mem_we[k], mem_addr[k]);
      end
      step();
      // a fresh request must issue immediately, proving the sequencer is idle
      core_req[k] = 1;
      @(negedge clk);
      n_tests++;
      if (mem_en[k] !== 1'b1 || core_ack[k] !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_idle: got en=%b cack=%b, required en=1 cack=0", mem_en[k], core_ack[k]);
      end
      step();
      core_req[k] = 0;
      step();
   endtask

   task automatic test_random(int k);
      bit          pc, pd, dwin, wwe;
      logic [31:0] waddr, wdata, exp_rd;
      do_reset(k);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_tests++;
         if (mem_en[k] !== 1'b0 || core_ack[k] !== 1'b0 || dma_ack[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL idle[%0d]: got en=%b cack=%b dack=%b, required all 0", k, mem_en[k], core_ack[k], dma_ack[k]);
         end
         step();
      end
      pc = 0; pd = 0;
      for (int it = 0; it < 200; it++) begin
         if (!pc && $urandom_range(0, 1) == 1) begin
            pc = 1;
            core_we[k]    = 1'($urandom_range(0, 1));
            core_addr[k]  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            core_wdata[k] = $urandom;
         end
         if (!pd && $urandom_range(0, 2) != 0) begin
            pd = 1;
            dma_we[k]    = 1'($urandom_range(0, 1));
            dma_addr[k]  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            dma_wdata[k] = $urandom;
         end
         core_req[k] = pc;
         dma_req[k]  = pd;
         @(negedge clk);
         if (!pc && !pd) begin
            n_tests++;
            if (mem_en[k] !== 1'b0 || core_ack[k] !== 1'b0 || dma_ack[k] !== 1'b0) begin
               n_fail++;
               $display("FAIL rnd_idle[%0d] it%0d: got en=%b cack=%b dack=%b, required 0", k, it, mem_en[k], core_ack[k], dma_ack[k]);
            end
            step();
            continue;
         end
         dwin  = model_pick(k, pc, pd);
         wwe   = dwin ? dma_we[k]    : core_we[k];
         waddr = dwin ? dma_addr[k]  : core_addr[k];
         wdata = dwin ? dma_wdata[k] : core_wdata[k];
         n_tests++;
         if (mem_en[k] !== 1'b1 || mem_we[k] !== wwe || mem_addr[k] !== waddr || mem_wdata[k] !== wdata || core_ack[k] !== 1'b0 || dma_ack[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_issue[%0d] it%0d: got en=%b we=%b addr=%h wd=%h cack=%b dack=%b, required en=1 we=%b addr=%h wd=%h (dma=%b)", k, it, mem_en[k], mem_we[k], mem_addr[k], mem_wdata[k], core_ack[k], dma_ack[k], wwe, waddr, wdata, dwin);
         end
         step();
         @(negedge clk);
         exp_rd = wwe ? 32'h0 : m_mem[k][waddr[9:2]];
         n_tests++;
         if (core_ack[k] !== !dwin || dma_ack[k] !== dwin || mem_en[k] !== 1'b0
             || (dwin ? dma_rdata[k] : core_rdata[k]) !== exp_rd
             || (dwin ? core_rdata[k] : dma_rdata[k]) !== 32'h0) begin
            n_fail++;
            $display("FAIL rnd_resp[%0d] it%0d: got cack=%b dack=%b crd=%h drd=%h en=%b, required cack=%b dack=%b rdata=%h", k, it, core_ack[k], dma_ack[k], core_rdata[k], dma_rdata[k], mem_en[k], !dwin, dwin, exp_rd);
         end
         if (wwe) m_mem[k][waddr[9:2]] = wdata;
         if (dwin) pd = 0;
         else      pc = 0;
         step();
      end
      clear_inputs(k);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         reset[k] = 1'b1;
         clear_inputs(k);
      end
      step();
      test_reset(0);
      test_reset(1);
      test_core_read(1);
      test_dma_wr_rd(0);
      test_contention(0, 2, "rr");
      test_contention(1, 4, "starve");
      test_reset_mid(1);
      test_random(0);
      test_random(1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
